// File: rtl/uart_pattern_tester_if.sv
// UART tester <-> UART_tx/UART_rx link: transmit word + strobe, frame-done, receive word + ready/ack.
// Latency: none (wires only).
// Backpressure: rdy stays high until the tester pulses clr_rdy; tx side is paced by tx_done.
// Ports: tx_data/trmt/clr_rdy are driven by the tester (master); tx_done/rx_data/rdy come from the UART pair (slave).
interface uart_pattern_tester_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              trmt;
  logic              tx_done;
  logic [DATA_W-1:0] rx_data;
  logic              rdy;
  logic              clr_rdy;

  modport master (
    output tx_data, trmt, clr_rdy,
    input  tx_done, rx_data, rdy
  );

  modport slave (
    input  tx_data, trmt, clr_rdy,
    output tx_done, rx_data, rdy
  );
endinterface

// File: rtl/uart_pattern_tester.sv
// UART loopback exerciser: sends BURST_LEN pattern words, checks each echo, counts mismatches/timeouts.
// Latency: per word SEND(1) + frame time + CHECK(1); next trmt directly follows CHECK.
// Backpressure: one word in flight; waits for tx_done and rdy (or TIMEOUT clocks) before the next word.
// Ports: clk/rst (sync, active-high); start/mode/seed control; uart (master side of the UART pair);
//        busy/done/pass/err_cnt/last_rx status.
module uart_pattern_tester #(
  parameter int                DATA_W    = 8,
  parameter int                BURST_LEN = 16,
  parameter logic [DATA_W-1:0] LFSR_TAPS = 8'hB8,
  parameter int                TIMEOUT   = 32768,
  parameter int                ERR_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [DATA_W-1:0]      seed,
  uart_pattern_tester_if.master  uart,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [ERR_W-1:0]       err_cnt,
  output logic [DATA_W-1:0]      last_rx
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int CW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_WAIT, S_CHECK, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pattern_q, pattern_d;
  logic [1:0]        mode_q, mode_d;
  logic [CW-1:0]     word_cnt_q, word_cnt_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              tx_seen_q, tx_seen_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [DATA_W-1:0] last_rx_q, last_rx_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;

  logic rx_hit, tmo_hit, last_word, miss;
  logic trmt_o, clr_rdy_o, busy_o;

  // The echo may beat tx_done by a cycle, so accept rdy together with tx_done as well.
  assign rx_hit    = uart.rdy && (tx_seen_q || uart.tx_done);
  assign tmo_hit   = (timer_q == TW'(TIMEOUT - 1));
  assign last_word = (word_cnt_q == CW'(BURST_LEN - 1));
  assign miss      = timeout_q || (uart.rx_data != pattern_q);

  function automatic logic [DATA_W-1:0] next_pattern(input logic [1:0] m,
                                                     input logic [DATA_W-1:0] p);
    case (m)
      2'b00:   return p + DATA_W'(1);
      2'b01:   return p[0] ? ((p >> 1) ^ LFSR_TAPS) : (p >> 1);
      2'b10:   return {p[DATA_W-2:0], p[DATA_W-1]};
      default: return p;
    endcase
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pattern_q  <= '0;
      mode_q     <= '0;
      word_cnt_q <= '0;
      timer_q    <= '0;
      tx_seen_q  <= 1'b0;
      timeout_q  <= 1'b0;
      tx_data_q  <= '0;
      err_cnt_q  <= '0;
      last_rx_q  <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pattern_q  <= pattern_d;
      mode_q     <= mode_d;
      word_cnt_q <= word_cnt_d;
      timer_q    <= timer_d;
      tx_seen_q  <= tx_seen_d;
      timeout_q  <= timeout_d;
      tx_data_q  <= tx_data_d;
      err_cnt_q  <= err_cnt_d;
      last_rx_q  <= last_rx_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_LOAD;
      S_LOAD:         state_d = S_SEND;
      S_SEND:         state_d = S_WAIT;
      S_WAIT:         if (rx_hit || tmo_hit) state_d = S_CHECK;
      S_CHECK:        state_d = last_word ? S_DONE : S_SEND;
      default:        state_d = S_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    pattern_d  = pattern_q;
    mode_d     = mode_q;
    word_cnt_d = word_cnt_q;
    timer_d    = timer_q;
    tx_seen_d  = tx_seen_q;
    timeout_d  = timeout_q;
    tx_data_d  = tx_data_q;
    err_cnt_d  = err_cnt_q;
    last_rx_d  = last_rx_q;
    done_d     = done_q;
    pass_d     = pass_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) pattern_d = seed;
      end
      S_LOAD: begin
        mode_d = mode;
        // LFSR and walking-one would lock up on an all-zero pattern.
        if ((mode == 2'b01 || mode == 2'b10) && pattern_q == '0)
          pattern_d = DATA_W'(1);
        word_cnt_d = '0;
        err_cnt_d  = '0;
        done_d     = 1'b0;
        pass_d     = 1'b0;
      end
      S_SEND: begin
        timer_d   = '0;
        tx_seen_d = 1'b0;
        timeout_d = 1'b0;
      end
      S_WAIT: begin
        timer_d = timer_q + TW'(1);
        if (uart.tx_done) tx_seen_d = 1'b1;
        // A word arriving in the timeout cycle still wins.
        timeout_d = tmo_hit && !rx_hit;
      end
      S_CHECK: begin
        if (!timeout_q) last_rx_d = uart.rx_data;
        if (miss && err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
        pattern_d = next_pattern(mode_q, pattern_q);
        if (last_word) begin
          done_d = 1'b1;
          pass_d = (err_cnt_d == '0);
        end else begin
          word_cnt_d = word_cnt_q + CW'(1);
        end
      end
      default: ;
    endcase

    // Present the word in the same cycle as trmt.
    if (state_d == S_SEND) tx_data_d = pattern_d;
  end

  // Outputs; strobes are masked by rst so an aborting reset never leaks a pulse.
  always_comb begin
    trmt_o    = (state_q == S_SEND) && !rst;
    clr_rdy_o = (state_q == S_CHECK) && !timeout_q && !rst;
    busy_o    = (state_q == S_LOAD) || (state_q == S_SEND) ||
                (state_q == S_WAIT) || (state_q == S_CHECK);
  end

  assign uart.trmt    = trmt_o;
  assign uart.clr_rdy = clr_rdy_o;
  assign uart.tx_data = tx_data_q;
  assign busy         = busy_o;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_cnt      = err_cnt_q;
  assign last_rx      = last_rx_q;
endmodule

// File: tb/tb_uart_pattern_tester.sv
// Bench for uart_pattern_tester: two instances (main and 2-bit error counter) with loopback models.
// Latency: loopback gives tx_done FRAME clocks after trmt and rdy RDY_DLY clocks after tx_done.
// Backpressure: loopback holds rdy until clr_rdy.
module tb_uart_pattern_tester;
  localparam int TMO     = 100;
  localparam int FRAME   = 12;
  localparam int RDY_DLY = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_assert = 0;
  int n_fail   = 0;

  // ---------------- main DUT ----------------
  logic       start_a = 1'b0;
  logic [1:0] mode_a  = 2'b00;
  logic [7:0] seed_a  = 8'h00;
  logic       busy_a, done_a, pass_a;
  logic [7:0] err_a, last_rx_a;
  uart_pattern_tester_if #(.DATA_W(8)) ua ();

  uart_pattern_tester #(
    .DATA_W(8), .BURST_LEN(4), .LFSR_TAPS(8'hB8), .TIMEOUT(TMO), .ERR_W(8)
  ) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .mode(mode_a), .seed(seed_a),
    .uart(ua), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_cnt(err_a), .last_rx(last_rx_a)
  );

  // ---------------- saturation DUT ----------------
  logic       start_s = 1'b0;
  logic [1:0] mode_s  = 2'b11;
  logic [7:0] seed_s  = 8'h55;
  logic       busy_s, done_s, pass_s;
  logic [1:0] err_s;
  logic [7:0] last_rx_s;
  uart_pattern_tester_if #(.DATA_W(8)) us ();

  uart_pattern_tester #(
    .DATA_W(8), .BURST_LEN(6), .LFSR_TAPS(8'hB8), .TIMEOUT(TMO), .ERR_W(2)
  ) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .mode(mode_s), .seed(seed_s),
    .uart(us), .busy(busy_s), .done(done_s), .pass(pass_s),
    .err_cnt(err_s), .last_rx(last_rx_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- loopback models (negedge, away from DUT edge) ----------------
  int         lb_ph_a = 0, lb_cnt_a = 0, lb_idx_a = 0;
  int         flip_idx_a = -1;
  bit         rdy_en_a = 1'b1;
  logic [7:0] lb_word_a;

  always @(negedge clk) begin
    if (rst) begin
      lb_ph_a = 0; lb_cnt_a = 0; lb_idx_a = 0;
      ua.rdy = 1'b0; ua.tx_done = 1'b0; ua.rx_data = 8'h00;
    end else begin
      if (start_a && !busy_a) lb_idx_a = 0;
      ua.tx_done = 1'b0;
      if (ua.clr_rdy) ua.rdy = 1'b0;
      if (ua.trmt) begin
        lb_word_a = ua.tx_data ^ ((lb_idx_a == flip_idx_a) ? 8'h01 : 8'h00);
        lb_idx_a++;
        lb_ph_a = 1; lb_cnt_a = 0;
      end else if (lb_ph_a == 1) begin
        lb_cnt_a++;
        if (lb_cnt_a == FRAME) begin ua.tx_done = 1'b1; lb_ph_a = 2; lb_cnt_a = 0; end
      end else if (lb_ph_a == 2) begin
        lb_cnt_a++;
        if (lb_cnt_a == RDY_DLY) begin
          lb_ph_a = 0;
          if (rdy_en_a) begin ua.rx_data = lb_word_a; ua.rdy = 1'b1; end
        end
      end
    end
  end

  int         lb_ph_s = 0, lb_cnt_s = 0;
  logic [7:0] lb_word_s;

  always @(negedge clk) begin
    if (rst) begin
      lb_ph_s = 0; lb_cnt_s = 0;
      us.rdy = 1'b0; us.tx_done = 1'b0; us.rx_data = 8'h00;
    end else begin
      us.tx_done = 1'b0;
      if (us.clr_rdy) us.rdy = 1'b0;
      if (us.trmt) begin
        lb_word_s = us.tx_data ^ 8'h01;  // every word corrupted
        lb_ph_s = 1; lb_cnt_s = 0;
      end else if (lb_ph_s == 1) begin
        lb_cnt_s++;
        if (lb_cnt_s == FRAME) begin us.tx_done = 1'b1; lb_ph_s = 2; lb_cnt_s = 0; end
      end else if (lb_ph_s == 2) begin
        lb_cnt_s++;
        if (lb_cnt_s == RDY_DLY) begin lb_ph_s = 0; us.rx_data = lb_word_s; us.rdy = 1'b1; end
      end
    end
  end

  // ---------------- scoreboard monitors ----------------
  logic [7:0] exp_a[$];
  logic [7:0] exp_s[$];
  int trmt_n_a = 0, clr_n_a = 0, trmt_n_s = 0;
  int trmt_t_a[$];

  always @(negedge clk) begin
    if (ua.trmt) begin
      trmt_n_a++;
      trmt_t_a.push_back(cyc);
      check("a_tx_expected", exp_a.size() != 0, 1);
      if (exp_a.size() != 0) check("a_tx_data", ua.tx_data, exp_a.pop_front());
    end
    if (ua.clr_rdy) clr_n_a++;
    if (us.trmt) begin
      trmt_n_s++;
      check("s_tx_expected", exp_s.size() != 0, 1);
      if (exp_s.size() != 0) check("s_tx_data", us.tx_data, exp_s.pop_front());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_burst_a(input logic [1:0] m, input logic [7:0] s);
    mode_a = m; seed_a = s; start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    tick(1);
  endtask

  task automatic wait_done_a(input string tag, input int budget);
    int n = 0;
    while (!done_a && n < budget) begin tick(1); n++; end
    check({tag, "_done"}, done_a, 1);
  endtask

  task automatic wait_trmt_a(input int target, input int budget);
    int n = 0;
    while (trmt_n_a < target && n < budget) begin tick(1); n++; end
    check("a_trmt_reached", trmt_n_a >= target, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base_t, base_c, base_i;

    tick(3);
    rst = 1'b0;
    // Reset state
    check("rst_tx_data", ua.tx_data, 8'h00);
    check("rst_trmt", ua.trmt, 0);
    check("rst_clr_rdy", ua.clr_rdy, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_err", err_a, 0);
    check("rst_last_rx", last_rx_a, 0);

    // 1. Increment with wrap
    base_t = trmt_n_a; base_c = clr_n_a;
    exp_a.push_back(8'hFE); exp_a.push_back(8'hFF);
    exp_a.push_back(8'h00); exp_a.push_back(8'h01);
    start_burst_a(2'b00, 8'hFE);
    check("t1_busy", busy_a, 1);
    wait_done_a("t1", 500);
    check("t1_trmt_cnt", trmt_n_a - base_t, 4);
    check("t1_clr_cnt", clr_n_a - base_c, 4);
    check("t1_pass", pass_a, 1);
    check("t1_err", err_a, 0);
    check("t1_last_rx", last_rx_a, 8'h01);
    check("t1_busy_end", busy_a, 0);

    // 2. LFSR with zero seed
    exp_a.push_back(8'h01); exp_a.push_back(8'hB8);
    exp_a.push_back(8'h5C); exp_a.push_back(8'h2E);
    start_burst_a(2'b01, 8'h00);
    check("t2_done_cleared", done_a, 0);
    wait_done_a("t2", 500);
    check("t2_pass", pass_a, 1);
    check("t2_last_rx", last_rx_a, 8'h2E);

    // 3. Walking-one, second word corrupted
    flip_idx_a = 1;
    exp_a.push_back(8'h40); exp_a.push_back(8'h80);
    exp_a.push_back(8'h01); exp_a.push_back(8'h02);
    start_burst_a(2'b10, 8'h40);
    wait_done_a("t3", 500);
    check("t3_err", err_a, 1);
    check("t3_pass", pass_a, 0);
    check("t3_last_rx", last_rx_a, 8'h02);
    flip_idx_a = -1;

    // 4. Timeouts: receiver never answers
    rdy_en_a = 1'b0;
    base_c = clr_n_a; base_i = trmt_t_a.size();
    exp_a.push_back(8'h10); exp_a.push_back(8'h11);
    exp_a.push_back(8'h12); exp_a.push_back(8'h13);
    start_burst_a(2'b00, 8'h10);
    wait_done_a("t4", 1000);
    check("t4_clr_cnt", clr_n_a - base_c, 0);
    check("t4_err", err_a, 4);
    check("t4_pass", pass_a, 0);
    check("t4_last_rx_kept", last_rx_a, 8'h02);
    check("t4_trmt_samples", trmt_t_a.size() - base_i, 4);
    for (int i = 1; i < 4; i++)
      if (base_i + i < trmt_t_a.size())
        check("t4_trmt_gap", trmt_t_a[base_i + i] - trmt_t_a[base_i + i - 1], TMO + 2);
    rdy_en_a = 1'b1;

    // 5. Ignored start during WAIT, then reset mid-burst
    base_t = trmt_n_a;
    exp_a.push_back(8'hA5); exp_a.push_back(8'hA5);
    start_burst_a(2'b11, 8'hA5);
    wait_trmt_a(base_t + 1, 200);
    tick(3);
    mode_a = 2'b00; seed_a = 8'h3C; start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    wait_trmt_a(base_t + 2, 200);
    tick(3);
    check("t5_busy_before_rst", busy_a, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t5_busy", busy_a, 0);
    check("t5_trmt", ua.trmt, 0);
    check("t5_err", err_a, 0);
    check("t5_tx_data", ua.tx_data, 8'h00);
    check("t5_done", done_a, 0);
    check("t5_sb_empty", exp_a.size(), 0);
    tick(5);
    check("t5_stays_idle", busy_a, 0);
    exp_a.push_back(8'h77); exp_a.push_back(8'h78);
    exp_a.push_back(8'h79); exp_a.push_back(8'h7A);
    start_burst_a(2'b00, 8'h77);
    wait_done_a("t5b", 500);
    check("t5b_pass", pass_a, 1);
    check("t5b_last_rx", last_rx_a, 8'h7A);

    // 6. Error counter saturation (2-bit counter, 6 corrupted words)
    base_t = trmt_n_s;
    for (int i = 0; i < 6; i++) exp_s.push_back(8'h55);
    mode_s = 2'b11; seed_s = 8'h55; start_s = 1'b1;
    tick(1);
    start_s = 1'b0;
    tick(1);
    begin
      int n = 0;
      while (!done_s && n < 800) begin tick(1); n++; end
    end
    check("t6_done", done_s, 1);
    check("t6_trmt_cnt", trmt_n_s - base_t, 6);
    check("t6_err_sat", err_s, 2'd3);
    check("t6_pass", pass_s, 0);
    check("t6_last_rx", last_rx_s, 8'h54);

    check("sb_a_drained", exp_a.size(), 0);
    check("sb_s_drained", exp_s.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_pattern_tester.md
Name: uart_pattern_tester

Overview:
Self-checking UART loopback exerciser that replaces the fixed 8-bit counter data source of the board-level UART test. On a start pulse it transmits a burst of BURST_LEN words through an external UART transmitter. Each word comes from a selectable pattern generator. Every word returned by an external UART receiver is compared against the expected value, and mismatches and timeouts are counted. It sits between the button edge detector and the UART_tx/UART_rx pair; last_rx drives the LEDs.

Parameters:
DATA_W, 8, width of each UART data word and of the pattern.
BURST_LEN, 16, words sent per start; legal range 1..65535.
LFSR_TAPS, 8'hB8, Galois LFSR feedback mask, DATA_W bits wide.
TIMEOUT, 32768, clocks allowed from trmt to receiver rdy.
ERR_W, 8, width of the error counter.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle pulse (already edge-detected); begins a burst
mode  in  2  pattern select: 00 increment, 01 LFSR, 10 walking-one, 11 constant
seed  in  DATA_W  first pattern value, sampled at start
tx_data  out  DATA_W  word to transmit
trmt  out  1  one-cycle transmit strobe to UART_tx
tx_done  in  1  UART_tx finished the frame (level or pulse)
rx_data  in  DATA_W  received word from UART_rx
rdy  in  1  UART_rx has a valid word
clr_rdy  out  1  one-cycle acknowledge to UART_rx
busy  out  1  burst in progress
done  out  1  burst finished; held until the next start
pass  out  1  done with err_cnt==0
err_cnt  out  ERR_W  mismatches plus timeouts in the last burst; saturating
last_rx  out  DATA_W  most recent received word (for the LEDs)

Behaviour:
- Reset state: FSM=IDLE. tx_data, err_cnt, last_rx = 0. trmt, clr_rdy, busy, done, pass = 0. Internal word counter and timer = 0. A reset asserted mid-burst aborts it immediately; a trmt or clr_rdy pulse in that cycle is suppressed.
- FSM states: IDLE, LOAD, SEND, WAIT, CHECK, DONE.
- IDLE/DONE:
  - start moves to LOAD.
  - start seen in any other state is ignored.
  - Mode changes are ignored except at LOAD.
- LOAD (1 cycle):
  - pattern <= seed; mode is latched.
  - In walking-one or LFSR mode, a zero seed is replaced by 1.
  - word_cnt <= 0, err_cnt <= 0, done <= 0, pass <= 0.
  - Goes to SEND.
- SEND (1 cycle):
  - tx_data <= pattern, trmt=1, timer <= 0, tx_seen <= 0.
  - Goes to WAIT.
- WAIT:
  - The timer increments every cycle.
  - tx_seen is set on tx_done.
  - Exit to CHECK when (rdy and tx_seen), or when rdy and tx_done occur in the same cycle.
  - Exit to CHECK with a timeout flag when timer reaches TIMEOUT-1.
  - Stays in WAIT otherwise.
- CHECK (1 cycle):
  - If rdy path: clr_rdy=1, last_rx <= rx_data, err_cnt++ when rx_data != pattern.
  - If timeout: err_cnt++ and no clr_rdy.
  - err_cnt saturates at 2^ERR_W-1.
  - pattern advances as follows:
    - increment: +1 modulo 2^DATA_W, wraps to 0.
    - LFSR: shift right; if the old LSB was 1, XOR with LFSR_TAPS.
    - walking-one: rotate left by 1, so the MSB wraps to bit 0.
    - constant: hold.
  - If word_cnt==BURST_LEN-1, go to DONE; otherwise word_cnt++ and go to SEND.
- DONE: done=1; pass=(err_cnt==0); both held until LOAD.
- busy=1 in LOAD, SEND, WAIT and CHECK; 0 in IDLE and DONE.
- Latency per word with an ideal loopback: SEND + frame time + 1 CHECK cycle. The next trmt follows the CHECK cycle on the next clock.
- A rdy that arrives outside WAIT is not acknowledged until the CHECK of the next word. A stale word arriving this way counts as a mismatch unless it happens to equal the expected value.

Test Plan:
1. Increment wrap: rst, then start with mode=00, seed=8'hFE, BURST_LEN=4, ideal loopback (rx_data=tx_data, rdy 10 clk after tx_done). Required: tx_data sequence FE, FF, 00, 01; 4 trmt and 4 clr_rdy pulses; done=1, pass=1, err_cnt=0, last_rx=01.
2. LFSR zero-seed: mode=01, seed=0, BURST_LEN=3, taps B8. Required: tx_data sequence 01, B8, 5C; pass=1.
3. Walking-one with corruption: mode=10, seed=8'h40, BURST_LEN=4. The loopback flips bit0 on the 2nd word. Required: sequence 40, 80, 01, 02; err_cnt=1; pass=0; last_rx=02.
4. Timeout: rdy never asserted, TIMEOUT=100, BURST_LEN=2. Required: each word leaves WAIT exactly 100 clocks after trmt; no clr_rdy; err_cnt=2; done=1 with pass=0.
5. Ignored start, then reset mid-burst: start pulsed again during WAIT is ignored (no reload). rst asserted in WAIT of word 2. Required next cycle: busy=0, trmt=0, err_cnt=0, tx_data=0, FSM IDLE. A following start begins a fresh burst from seed.
6. Saturation: ERR_W=2, BURST_LEN=6, all words corrupted. Required: err_cnt saturates at 3; done=1 after 6 words.
